// File: rtl/piso_serializer_pkg.sv
// Shared types for the parallel-in/serial-out serializer: FSM state encoding
// and the beat-counter width rule max(1, clog2(DEPTH)).
package piso_serializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } pisoState_t;

    function automatic int unsigned cntWidth(input int unsigned depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Frame-in / word-out handshake bundle for piso_serializer.
// The slave modport is the serializer side; master is the upstream/downstream side.
interface piso_serializer_if #(
    parameter int unsigned BITWIDTH = 32,
    parameter int unsigned DEPTH    = 8
);
    logic                         iValid;
    logic                         oReady;
    logic [BITWIDTH*DEPTH-1:0]    iData;
    logic                         oValid;
    logic                         iReady;
    logic [BITWIDTH-1:0]          oData;
    logic                         oLast;

    modport master (
        output iValid, iData, iReady,
        input  oReady, oValid, oData, oLast
    );

    modport slave (
        input  iValid, iData, iReady,
        output oReady, oValid, oData, oLast
    );
endinterface

// File: rtl/piso_beat_counter.sv
// Modulo-DEPTH beat counter with enable, synchronous clear and a terminal-count
// flag that is high while the counter sits on DEPTH-1.
module piso_beat_counter
    import piso_serializer_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    localparam int unsigned CW   = cntWidth(DEPTH)
) (
    input  logic          iClk,
    input  logic          iRstN,
    input  logic          iEn,
    input  logic          iClr,
    input  logic          iStep,
    output logic [CW-1:0] oCount,
    output logic          oTerminal
);
    localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

    assign oTerminal = (oCount == LAST);

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            oCount <= '0;
        end else if (iClr) begin
            oCount <= '0;
        end else if (iEn && iStep) begin
            oCount <= oTerminal ? '0 : oCount + CW'(1);
        end
    end
endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer: loads DEPTH words in one transfer and emits
// them one per beat with oLast on the final word. Build option: PISO_SERIALIZER_MSB_FIRST_EN.
module piso_serializer
    import piso_serializer_pkg::*;
#(
    parameter int unsigned BITWIDTH = 32,
    parameter int unsigned DEPTH    = 8
) (
    input  logic            iClk,
    input  logic            iRstN,
    input  logic            iEn,
    input  logic            iClr,
    piso_serializer_if.slave bus
);
    localparam int unsigned CW = cntWidth(DEPTH);

    pisoState_t         state;
    pisoState_t         stateNext;
    logic [BITWIDTH-1:0] buffer [DEPTH];
    logic [CW-1:0]      count;
    logic               terminal;
    logic               loadFire;
    logic               beatFire;
    int unsigned        wordSel;

    assign bus.oReady = iRstN && iEn && (state == IDLE);
    assign bus.oValid = (state == SHIFT);
    // iClr overrides any handshake that happens to coincide with it
    assign loadFire   = bus.iValid && bus.oReady && !iClr;
    assign beatFire   = bus.oValid && bus.iReady && iEn && !iClr;

    piso_beat_counter #(
        .DEPTH(DEPTH)
    ) uBeatCounter (
        .iClk     (iClk),
        .iRstN    (iRstN),
        .iEn      (iEn),
        .iClr     (iClr || loadFire),
        .iStep    (beatFire),
        .oCount   (count),
        .oTerminal(terminal)
    );

    for (genvar k = 0; k < DEPTH; k++) begin : gWord
        always_ff @(posedge iClk or negedge iRstN) begin
            if (!iRstN) begin
                buffer[k] <= '0;
            end else if (iClr) begin
                buffer[k] <= '0;
            end else if (loadFire) begin
                buffer[k] <= bus.iData[k*BITWIDTH +: BITWIDTH];
            end
        end
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        if (iClr) begin
            stateNext = IDLE;
        end else begin
            case (state)
                IDLE:    if (loadFire) stateNext = SHIFT;
                SHIFT:   if (beatFire && terminal) stateNext = IDLE;
                default: stateNext = IDLE;
            endcase
        end
    end

    // oLast tracks the counter, so it lands on the last emitted word in either order
    always_comb begin
`ifdef PISO_SERIALIZER_MSB_FIRST_EN
        wordSel = (DEPTH - 1) - 32'(count);
`else
        wordSel = 32'(count);
`endif
        bus.oData = '0;
        bus.oLast = 1'b0;
        if (state == SHIFT) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                if (k == wordSel) bus.oData = buffer[k];
            end
            bus.oLast = terminal;
        end
    end
endmodule

// File: tb/tb_piso_serializer.sv
// Randomized and directed bench for piso_serializer (BITWIDTH=8, DEPTH=4) against a
// queue-based frame model; honours PISO_SERIALIZER_MSB_FIRST_EN for emission order.
module tb_piso_serializer;
    localparam int unsigned BW = 8;
    localparam int unsigned DP = 4;

    logic iClk;
    logic iRstN;
    logic iEn;
    logic iClr;

    piso_serializer_if #(.BITWIDTH(BW), .DEPTH(DP)) bus ();

    piso_serializer #(.BITWIDTH(BW), .DEPTH(DP)) dut (
        .iClk (iClk),
        .iRstN(iRstN),
        .iEn  (iEn),
        .iClr (iClr),
        .bus  (bus.slave)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    int checks = 0;
    int fails  = 0;

    // Model: words still to be emitted, front = current word; empty means idle
    logic [BW-1:0] q [$];
    logic          sV, sRdy, sEn, sClr;
    logic [31:0]   sD;

    function automatic logic [10:0] expOut();
        logic busy;
        busy = (q.size() != 0);
        return {(!busy && sEn), busy, (busy && q.size() == 1), (busy ? q[0] : 8'h00)};
    endfunction

    function automatic logic [10:0] obsOut();
        return {bus.oReady, bus.oValid, bus.oLast, bus.oData};
    endfunction

    task automatic apply(input logic v, input logic [31:0] d, input logic rdy,
                         input logic en, input logic clr);
        bus.iValid = v;
        bus.iData  = d;
        bus.iReady = rdy;
        iEn        = en;
        iClr       = clr;
        sV = v; sD = d; sRdy = rdy; sEn = en; sClr = clr;
        #1;
    endtask

    task automatic commit();
        logic    busy;
        logic [BW-1:0] w;
        busy = (q.size() != 0);
        if (sClr) begin
            q.delete();
        end else if (sEn) begin
            if (busy && sRdy) begin
                void'(q.pop_front());
            end else if (!busy && sV) begin
                for (int k = 0; k < DP; k++) begin
                    w = sD[k*BW +: BW];
`ifdef PISO_SERIALIZER_MSB_FIRST_EN
                    q.push_front(w);
`else
                    q.push_back(w);
`endif
                end
            end
        end
        @(negedge iClk);
    endtask

    task automatic test_reset();
        iRstN = 1'b0;
        apply(1'b1, 32'h12345678, 1'b1, 1'b1, 1'b0);
        checks++;
        if (obsOut() !== 11'h000) begin
            fails++;
            $display("FAIL reset_low got=%h want=%h", obsOut(), 11'h000);
        end
        @(negedge iClk);
        iRstN = 1'b1;
        apply(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (obsOut() !== 11'h400) begin
            fails++;
            $display("FAIL reset_idle got=%h want=%h", obsOut(), 11'h400);
        end
        commit();
    endtask

    task automatic test_basic();
        logic [31:0] seen;
        logic [31:0] want;
        seen = '0;
`ifdef PISO_SERIALIZER_MSB_FIRST_EN
        want = 32'h11223344;
`else
        want = 32'h44332211;
`endif
        for (int i = 0; i < 6; i++) begin
            apply(i == 0, 32'h44332211, 1'b1, 1'b1, 1'b0);
            checks++;
            if (obsOut() !== expOut()) begin
                fails++;
                $display("FAIL basic cyc%0d got=%h want=%h", i, obsOut(), expOut());
            end
            if (bus.oValid) seen = {bus.oData, seen[31:8]};
            commit();
        end
        checks++;
        if (seen !== want) begin
            fails++;
            $display("FAIL basic_order got=%h want=%h", seen, want);
        end
    endtask

    task automatic test_backpressure();
        logic rdy [9] = '{1, 1, 0, 0, 0, 1, 1, 1, 1};
        for (int i = 0; i < 9; i++) begin
            apply(i == 0, 32'h44332211, rdy[i], 1'b1, 1'b0);
            checks++;
            if (obsOut() !== expOut()) begin
                fails++;
                $display("FAIL backpressure cyc%0d got=%h want=%h", i, obsOut(), expOut());
            end
            commit();
        end
    endtask

    task automatic test_enable();
        logic en [8] = '{1, 1, 0, 0, 1, 1, 1, 1};
        for (int i = 0; i < 8; i++) begin
            apply(i == 0, 32'h8877_6655, 1'b1, en[i], 1'b0);
            checks++;
            if (obsOut() !== expOut()) begin
                fails++;
                $display("FAIL enable cyc%0d got=%h want=%h", i, obsOut(), expOut());
            end
            commit();
        end
    endtask

    task automatic test_clear();
        for (int i = 0; i < 10; i++) begin
            apply(i == 0 || i == 4, (i < 4) ? 32'h44332211 : 32'hDDCCBBAA,
                  1'b1, 1'b1, i == 3);
            checks++;
            if (obsOut() !== expOut()) begin
                fails++;
                $display("FAIL clear cyc%0d got=%h want=%h", i, obsOut(), expOut());
            end
            commit();
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 16; i++) begin
            apply(1'b1, $urandom, 1'b1, 1'b1, 1'b0);
            checks++;
            if (obsOut() !== expOut()) begin
                fails++;
                $display("FAIL b2b cyc%0d got=%h want=%h", i, obsOut(), expOut());
            end
            commit();
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) begin
            apply(i == 0, 32'hA5A5_5A5A, 1'b1, 1'b1, 1'b0);
            commit();
        end
        #2;
        iRstN = 1'b0;
        #1;
        checks++;
        if (obsOut() !== 11'h000) begin
            fails++;
            $display("FAIL async_reset got=%h want=%h", obsOut(), 11'h000);
        end
        q.delete();
        @(negedge iClk);
        iRstN = 1'b1;
        apply(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        checks++;
        if (obsOut() !== expOut()) begin
            fails++;
            $display("FAIL async_reset_after got=%h want=%h", obsOut(), expOut());
        end
        commit();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            apply($urandom_range(0, 1) == 1, $urandom,
                  $urandom_range(0, 9) < 7, $urandom_range(0, 19) < 17,
                  $urandom_range(0, 39) == 0);
            checks++;
            if (obsOut() !== expOut()) begin
                fails++;
                $display("FAIL random cyc%0d got=%h want=%h", i, obsOut(), expOut());
            end
            commit();
        end
    endtask

    initial begin
        iRstN      = 1'b0;
        iEn        = 1'b0;
        iClr       = 1'b0;
        bus.iValid = 1'b0;
        bus.iData  = '0;
        bus.iReady = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_enable();
        test_clear();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
